ncl_mult3_sched: RTL and testbench
==================================

Name: ncl_mult3_sched

Overview:
- Synchronous scheduler that shares one NCL_MULT3 dual-rail 3x3 multiplier between N clocked requesters.
- Grants requesters round-robin and drives DATA and NULL wavefronts on the dual-rail operand rails.
- Runs the four-phase Ki/Ko handshake and detects product completeness and NULL through synchronizers.
- Returns each 6-bit product to the clocked fabric on a valid/ready response port.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flop stages on every asynchronous input (mult_ko, all product rails).
- STABLE_CYC, 2, consecutive synchronized cycles a completeness or NULL condition must hold before it is accepted.
- WDOG_CYC, 255, watchdog limit in cycles (used only with NCL_WATCHDOG_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request
- req_ready  out  N_REQ  one-hot grant/accept pulse
- req_a  in  3*N_REQ  operand A, requester i at [3i+2:3i]
- req_b  in  3*N_REQ  operand B, same packing as req_a
- resp_valid  out  1  result available
- resp_ready  in  1  result consumed
- resp_id  out  $clog2(N_REQ)  index of the requester that owns the result
- resp_prod  out  6  product A*B
- mult_a_rail1, mult_a_rail0  out  3 each  dual-rail operand A to multiplier
- mult_b_rail1, mult_b_rail0  out  3 each  dual-rail operand B to multiplier
- mult_ki  out  1  request to multiplier: 1 = request DATA, 0 = request NULL
- mult_ko  in  1  multiplier acknowledge (async): 1 = ready for DATA, 0 = ready for NULL
- mult_p_rail1, mult_p_rail0  in  6 each  dual-rail product (async)
- busy  out  1  FSM not in IDLE
- illegal_err  out  1  sticky: a product pair showed 11
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset values:
  - All operand rails 0 (NULL); mult_ki=0.
  - req_ready=0, resp_valid=0, resp_id=0, resp_prod=0.
  - busy=1, both error flags 0.
  - RR pointer set so requester 0 has top priority.
  - FSM enters FLUSH.
- Asynchronous inputs are used only after SYNC_STAGES flops.
- Completeness flags (synchronized domain):
  - data_seen: every product pair is exactly 01 or 10 for STABLE_CYC consecutive cycles.
  - null_seen: every product pair is 00 for STABLE_CYC consecutive cycles.
  - A pair at 11 never counts toward either flag.
- FSM, all outputs registered:
  - FLUSH: operands NULL, mult_ki=0. When null_seen && ko_s=1, go to IDLE.
  - IDLE: operands NULL, mult_ki=1, busy=0. If any req_valid && !resp_valid:
    - grant the first valid requester after the last granted one (wrapping);
    - pulse req_ready[g] for one cycle and latch its A, B and g;
    - go to DATA.
  - DATA: drive latched operands (1 -> rail1=1/rail0=0, 0 -> rail1=0/rail0=1), mult_ki=1. When data_seen && ko_s=0:
    - capture resp_prod = rail1 bits and resp_id = g;
    - set resp_valid the next cycle;
    - go to NULLW.
  - NULLW: operands NULL, mult_ki=0. When null_seen && ko_s=1, go to IDLE.
- Operand rails never change in the same cycle as a DATA<->NULL transition of mult_ki in the wrong direction; operands go NULL no earlier than mult_ki falls.
- Response port:
  - resp_valid holds, with resp_prod/resp_id stable, until resp_ready is sampled high; it clears the following cycle.
  - No new grant while resp_valid=1. A grant may occur in the cycle after the handshake completes.
- Simultaneous requests: exactly one grant per cycle, round-robin fair. A requester that drops req_valid before its grant is skipped.
- Minimum latency, grant to resp_valid: SYNC_STAGES+STABLE_CYC+2 cycles. The actual latency depends on multiplier delay.
- illegal_err: set when any synchronized pair is 11 for STABLE_CYC cycles. It is cleared only by rst_n.
- Reset asserted mid-operation: outputs return to their reset values immediately (asynchronously). Any pending result is discarded. After release the FSM runs FLUSH before serving requests.

Optional Feature:
- NCL_WATCHDOG_EN defined:
  - An 8+ bit counter runs in FLUSH, DATA and NULLW and clears on every state change.
  - On reaching WDOG_CYC it sets timeout_err (sticky until reset) and forces FLUSH. Any in-flight result is dropped and no response is issued.
- NCL_WATCHDOG_EN undefined: no counter; FSM waits indefinitely; timeout_err tied 0.

Test Plan:
- Reset then req_valid[0] with A=2, B=7:
  - req_ready[0] pulses once, then resp_prod=6'b001110 with resp_id=0.
  - mult_ki sequence: 0 (FLUSH) -> 1 -> 0 after data -> 1.
  - Operand rails: a=10/01 per bit, b all 10.
- Exhaustive: requester 1, all 64 A/B pairs back-to-back with resp_ready=1 -> each resp_prod equals A*B and resp_id=1; illegal_err stays 0.
- Contention: N_REQ=4, all req_valid held high -> grant order 0,1,2,3,0,1; resp_id follows the same order.
- Backpressure: resp_ready=0 for 20 cycles with req_valid[2]=1 pending:
  - resp_valid and its data stay stable; no req_ready pulse.
  - After resp_ready=1 the next grant goes to requester 2.
- Reset mid-DATA: pull rst_n low while operands are DATA:
  - all rails 0, mult_ki=0, resp_valid=0 immediately.
  - After release the FSM passes FLUSH and a new 3x3 request returns 9.
- Fault: force product pair 3 to 11 -> illegal_err=1 and stays 1. With NCL_WATCHDOG_EN and mult_ko stuck at 1 in DATA -> timeout_err=1 after WDOG_CYC cycles, then FSM in FLUSH with no response issued.

Source files
------------

// File: rtl/ncl_mult3_sched.sv
// ncl_mult3_sched: shares one dual-rail NCL 3x3 multiplier between N_REQ clocked
// requesters. A round-robin arbiter picks a requester, the FSM drives DATA/NULL
// wavefronts with a four-phase Ki/Ko handshake, and each product comes back
// on a valid/ready response port.
// Optional build macro NCL_WATCHDOG_EN adds a stuck-handshake watchdog that
// sets timeout_err and forces the FSM back to FLUSH.
module ncl_mult3_sched #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned STABLE_CYC  = 2,
  parameter int unsigned WDOG_CYC    = 255,
  localparam int unsigned ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [3*N_REQ-1:0]   req_a,
  input  logic [3*N_REQ-1:0]   req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [5:0]           resp_prod,
  output logic [2:0]           mult_a_rail1,
  output logic [2:0]           mult_a_rail0,
  output logic [2:0]           mult_b_rail1,
  output logic [2:0]           mult_b_rail0,
  output logic                 mult_ki,
  input  logic                 mult_ko,
  input  logic [5:0]           mult_p_rail1,
  input  logic [5:0]           mult_p_rail0,
  output logic                 busy,
  output logic                 illegal_err,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DATA  = 2'd2,
    ST_NULLW = 2'd3
  } state_t;

  localparam int unsigned       CNT_W   = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYC);

  // synchronizer chains
  logic [SYNC_STAGES-1:0]       r_ko_sync;
  logic [SYNC_STAGES-1:0][5:0]  r_p1_sync;
  logic [SYNC_STAGES-1:0][5:0]  r_p0_sync;
  logic                         w_ko_s;
  logic [5:0]                   w_p1_s;
  logic [5:0]                   w_p0_s;

  // completeness detection
  logic                         w_data_now;
  logic                         w_null_now;
  logic                         w_ill_now;
  logic [CNT_W-1:0]             r_data_cnt;
  logic [CNT_W-1:0]             r_null_cnt;
  logic [CNT_W-1:0]             r_ill_cnt;
  logic                         w_data_seen;
  logic                         w_null_seen;
  logic                         r_illegal;

  // FSM and registered outputs
  state_t                       r_state;
  logic [2:0]                   r_a1, r_a0, r_b1, r_b0;
  logic                         r_ki;
  logic [N_REQ-1:0]             r_req_ready;
  logic                         r_resp_valid;
  logic [ID_W-1:0]              r_resp_id;
  logic [5:0]                   r_resp_prod;
  logic                         r_busy;
  logic                         r_cap;
  logic [ID_W-1:0]              r_last;

  // arbitration
  logic                         w_gnt_found;
  logic [ID_W-1:0]              w_gnt_idx;
  logic [N_REQ-1:0]             w_gnt_onehot;
  logic [2:0]                   w_sel_a;
  logic [2:0]                   w_sel_b;

  logic                         w_wdog_hit;

  assign w_ko_s = r_ko_sync[SYNC_STAGES-1];
  assign w_p1_s = r_p1_sync[SYNC_STAGES-1];
  assign w_p0_s = r_p0_sync[SYNC_STAGES-1];

  // Bring the asynchronous multiplier outputs into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ko_sync <= '0;
      r_p1_sync <= '0;
      r_p0_sync <= '0;
    end else begin
      r_ko_sync[0] <= mult_ko;
      r_p1_sync[0] <= mult_p_rail1;
      r_p0_sync[0] <= mult_p_rail0;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        r_ko_sync[s] <= r_ko_sync[s-1];
        r_p1_sync[s] <= r_p1_sync[s-1];
        r_p0_sync[s] <= r_p0_sync[s-1];
      end
    end
  end

  // A pair at 11 is neither valid data nor NULL, so it breaks both conditions
  assign w_data_now = &(w_p1_s ^ w_p0_s);
  assign w_null_now = &(~(w_p1_s | w_p0_s));
  assign w_ill_now  = |(w_p1_s & w_p0_s);

  function automatic logic [CNT_W-1:0] f_stab(input logic cond, input logic [CNT_W-1:0] cnt);
    if (!cond)
      return '0;
    else if (cnt == CNT_MAX)
      return cnt;
    else
      return cnt + 1'b1;
  endfunction

  // Count consecutive cycles each synchronized product condition holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_cnt <= '0;
      r_null_cnt <= '0;
      r_ill_cnt  <= '0;
    end else begin
      r_data_cnt <= f_stab(w_data_now, r_data_cnt);
      r_null_cnt <= f_stab(w_null_now, r_null_cnt);
      r_ill_cnt  <= f_stab(w_ill_now, r_ill_cnt);
    end
  end

  assign w_data_seen = (r_data_cnt == CNT_MAX);
  assign w_null_seen = (r_null_cnt == CNT_MAX);

  // Sticky flag for a persistent 11 product pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_illegal <= 1'b0;
    else if (r_ill_cnt == CNT_MAX)
      r_illegal <= 1'b1;
  end

  // Round-robin pick: first valid requester after the last granted one
  always_comb begin
    logic [ID_W-1:0] v_idx;
    v_idx        = '0;
    w_gnt_found  = 1'b0;
    w_gnt_idx    = '0;
    w_gnt_onehot = '0;
    w_sel_a      = '0;
    w_sel_b      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      v_idx = ID_W'((32'(r_last) + k) % N_REQ);
      if (!w_gnt_found && req_valid[v_idx]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = v_idx;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_gnt_onehot[i] = 1'b1;
        w_sel_a         = req_a[3*i +: 3];
        w_sel_b         = req_b[3*i +: 3];
      end
    end
  end

`ifdef NCL_WATCHDOG_EN
  localparam int unsigned WD_W = ($clog2(WDOG_CYC + 1) > 8) ? $clog2(WDOG_CYC + 1) : 8;
  logic [WD_W-1:0] r_wdog;
  state_t          r_wd_state;
  logic            r_timeout;

  assign w_wdog_hit  = (r_wdog == WD_W'(WDOG_CYC));
  assign timeout_err = r_timeout;

  // Count cycles spent in one waiting state; any state change restarts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog     <= '0;
      r_wd_state <= ST_FLUSH;
      r_timeout  <= 1'b0;
    end else begin
      r_wd_state <= r_state;
      if (w_wdog_hit)
        r_timeout <= 1'b1;
      if (w_wdog_hit || (r_state == ST_IDLE) || (r_state != r_wd_state))
        r_wdog <= '0;
      else
        r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_wdog_hit  = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Scheduler FSM: grant, DATA wavefront, NULL wavefront, response hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FLUSH;
      r_a1         <= '0;
      r_a0         <= '0;
      r_b1         <= '0;
      r_b0         <= '0;
      r_ki         <= 1'b0;
      r_req_ready  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_prod  <= '0;
      r_busy       <= 1'b1;
      r_cap        <= 1'b0;
      r_last       <= ID_W'(N_REQ - 1);
    end else begin
      r_req_ready <= '0;
      r_cap       <= 1'b0;
      // capture happens a cycle before resp_valid rises; a capture can only
      // occur while resp_valid is low, so the two branches never collide
      if (r_cap)
        r_resp_valid <= 1'b1;
      else if (r_resp_valid && resp_ready)
        r_resp_valid <= 1'b0;

      if (w_wdog_hit) begin
        r_state <= ST_FLUSH;
        r_a1    <= '0;
        r_a0    <= '0;
        r_b1    <= '0;
        r_b0    <= '0;
        r_ki    <= 1'b0;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          ST_FLUSH, ST_NULLW: begin
            if (w_null_seen && w_ko_s) begin
              r_state <= ST_IDLE;
              r_ki    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          ST_IDLE: begin
            if (w_gnt_found && !r_resp_valid) begin
              r_state     <= ST_DATA;
              r_busy      <= 1'b1;
              r_req_ready <= w_gnt_onehot;
              r_last      <= w_gnt_idx;
              r_a1        <= w_sel_a;
              r_a0        <= ~w_sel_a;
              r_b1        <= w_sel_b;
              r_b0        <= ~w_sel_b;
            end
          end
          ST_DATA: begin
            if (w_data_seen && !w_ko_s) begin
              r_state     <= ST_NULLW;
              r_resp_prod <= w_p1_s;
              r_resp_id   <= r_last;
              r_cap       <= 1'b1;
              r_ki        <= 1'b0;
              r_a1        <= '0;
              r_a0        <= '0;
              r_b1        <= '0;
              r_b0        <= '0;
            end
          end
          default: r_state <= ST_FLUSH;
        endcase
      end
    end
  end

  assign req_ready    = r_req_ready;
  assign resp_valid   = r_resp_valid;
  assign resp_id      = r_resp_id;
  assign resp_prod    = r_resp_prod;
  assign mult_a_rail1 = r_a1;
  assign mult_a_rail0 = r_a0;
  assign mult_b_rail1 = r_b1;
  assign mult_b_rail0 = r_b0;
  assign mult_ki      = r_ki;
  assign busy         = r_busy;
  assign illegal_err  = r_illegal;

endmodule

// File: tb/tb_ncl_mult3_sched.sv
// Testbench for ncl_mult3_sched with a behavioural four-phase NCL multiplier.
`timescale 1ns/1ps
module tb_ncl_mult3_sched;
  localparam int unsigned N_REQ       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned STABLE_CYC  = 2;
  localparam int unsigned WDOG_CYC    = 255;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [N_REQ-1:0]  req_ready;
  logic [3*N_REQ-1:0] req_a = '0;
  logic [3*N_REQ-1:0] req_b = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [1:0]        resp_id;
  logic [5:0]        resp_prod;
  logic [2:0]        mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0;
  logic              mult_ki;
  logic              mult_ko;
  logic [5:0]        mult_p_rail1, mult_p_rail0;
  logic              busy, illegal_err, timeout_err;

  // multiplier model state and fault overrides
  logic [5:0]  m_p1 = '0;
  logic [5:0]  m_p0 = '0;
  logic        m_ko = 1'b1;
  logic        m_data = 1'b0;
  int unsigned m_dly = 0;
  logic [5:0]  f_p1 = '0;
  logic [5:0]  f_p0 = '0;
  logic        ko_stuck = 1'b0;

  typedef struct packed { logic [1:0] id; logic [5:0] prod; } exp_t;
  exp_t sb[$];

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  assign mult_p_rail1 = m_p1 | f_p1;
  assign mult_p_rail0 = m_p0 | f_p0;
  assign mult_ko      = m_ko | ko_stuck;

  ncl_mult3_sched #(
    .N_REQ(N_REQ), .SYNC_STAGES(SYNC_STAGES), .STABLE_CYC(STABLE_CYC), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_prod(resp_prod),
    .mult_a_rail1(mult_a_rail1), .mult_a_rail0(mult_a_rail0),
    .mult_b_rail1(mult_b_rail1), .mult_b_rail0(mult_b_rail0),
    .mult_ki(mult_ki), .mult_ko(mult_ko),
    .mult_p_rail1(mult_p_rail1), .mult_p_rail0(mult_p_rail0),
    .busy(busy), .illegal_err(illegal_err), .timeout_err(timeout_err)
  );

  // NCL multiplier: DATA out when Ki=1 and inputs complete, NULL out when Ki=0 and inputs NULL,
  // each after a random 0..3 cycle delay, changing away from the scheduler's clock edge
  always @(negedge clk) begin
    if (!m_data) begin
      if (mult_ki && (&(mult_a_rail1 ^ mult_a_rail0)) && (&(mult_b_rail1 ^ mult_b_rail0))) begin
        if (m_dly == 0) begin
          m_p1   <= {3'b000, mult_a_rail1} * {3'b000, mult_b_rail1};
          m_p0   <= ~({3'b000, mult_a_rail1} * {3'b000, mult_b_rail1});
          m_ko   <= 1'b0;
          m_data <= 1'b1;
          m_dly  <= $urandom_range(0, 3);
        end else begin
          m_dly <= m_dly - 1;
        end
      end
    end else if (!mult_ki && ({mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0} == 12'd0)) begin
      if (m_dly == 0) begin
        m_p1   <= '0;
        m_p0   <= '0;
        m_ko   <= 1'b1;
        m_data <= 1'b0;
        m_dly  <= $urandom_range(0, 3);
      end else begin
        m_dly <= m_dly - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare each accepted response with the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("resp_id", 32'(resp_id), 32'(e.id));
        check("resp_prod", 32'(resp_prod), 32'(e.prod));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int unsigned i, input int unsigned a, input int unsigned b);
    req_a[3*i +: 3] = 3'(a);
    req_b[3*i +: 3] = 3'(b);
  endtask

  task automatic push(input int unsigned id, input int unsigned a, input int unsigned b);
    exp_t e;
    e.id   = 2'(id);
    e.prod = 6'(a * b);
    sb.push_back(e);
  endtask

  task automatic wait_grant(input int unsigned idx, input string tag);
    int unsigned t = 0;
    @(negedge clk);
    while (req_ready == '0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(req_ready), 32'd1 << idx);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned t = 0;
    @(negedge clk);
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ki"}, 32'(mult_ki), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int unsigned t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rails"}, 32'({mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0}), 32'd0);
    check({tag, "_ki"}, 32'(mult_ki), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_id"}, 32'(resp_id), 32'd0);
    check({tag, "_resp_prod"}, 32'(resp_prod), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_illegal"}, 32'(illegal_err), 32'd0);
    check({tag, "_timeout"}, 32'(timeout_err), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    step();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals(tag);
    step();
    rst_n = 1'b1;
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned t;
    int unsigned order [6];
    logic ever_resp;
    order = '{0, 1, 2, 3, 0, 1};

    // reset and first transaction: requester 0, A=2, B=7
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    step();
    rst_n = 1'b1;
    wait_idle("flush");

    step();
    set_req(0, 2, 7);
    push(0, 2, 7);
    req_valid[0] = 1'b1;
    wait_grant(0, "t1_grant");
    check("t1_a1", 32'(mult_a_rail1), 32'b010);
    check("t1_a0", 32'(mult_a_rail0), 32'b101);
    check("t1_b1", 32'(mult_b_rail1), 32'b111);
    check("t1_b0", 32'(mult_b_rail0), 32'b000);
    check("t1_ki_data", 32'(mult_ki), 32'd1);
    step();
    req_valid[0] = 1'b0;
    t = 0;
    while (mult_ki !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t1_ki_fall", 32'(mult_ki), 32'd0);
    check("t1_rails_null", 32'({mult_a_rail1, mult_a_rail0, mult_b_rail1, mult_b_rail0}), 32'd0);
    check("t1_no_early_resp", 32'(resp_valid), 32'd0);
    while (resp_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    check("t1_min_latency", 32'(t >= SYNC_STAGES + STABLE_CYC + 2), 32'd1);
    check("t1_prod_direct", 32'(resp_prod), 32'b001110);
    wait_drain("t1_drain");
    wait_idle("t1_ki_rise");

    // exhaustive products on requester 1, back-to-back
    step();
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        set_req(1, a, b);
        push(1, a, b);
        req_valid[1] = 1'b1;
        wait_grant(1, "t2_grant");
        step();
      end
    end
    req_valid[1] = 1'b0;
    wait_drain("t2_drain");
    check("t2_illegal", 32'(illegal_err), 32'd0);

    // contention from a fresh reset: 0,1,2,3,0,1
    do_reset("rst2");
    step();
    for (int i = 0; i < 4; i++) set_req(i, i + 1, i + 2);
    for (int k = 0; k < 6; k++) push(order[k], order[k] + 1, order[k] + 2);
    req_valid = '1;
    for (int k = 0; k < 6; k++) wait_grant(order[k], "t3_grant");
    step();
    req_valid = '0;
    wait_drain("t3_drain");

    // backpressure: response held, requesters 2 and 3 pending
    step();
    resp_ready = 1'b0;
    set_req(0, 3, 5);
    push(0, 3, 5);
    req_valid[0] = 1'b1;
    wait_grant(0, "t4_grant0");
    step();
    req_valid[0] = 1'b0;
    t = 0;
    while (resp_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4_resp_valid", 32'(resp_valid), 32'd1);
    step();
    set_req(2, 6, 6);
    set_req(3, 7, 7);
    push(2, 6, 6);
    push(3, 7, 7);
    req_valid[2] = 1'b1;
    req_valid[3] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(resp_valid), 32'd1);
      check("t4_hold_prod", 32'(resp_prod), 32'd15);
      check("t4_hold_id", 32'(resp_id), 32'd0);
      check("t4_no_grant", 32'(req_ready), 32'd0);
    end
    step();
    resp_ready = 1'b1;
    wait_grant(2, "t4_grant2");
    step();
    req_valid[2] = 1'b0;
    wait_grant(3, "t4_grant3");
    step();
    req_valid[3] = 1'b0;
    wait_drain("t4_drain");

    // reset while operands are DATA
    step();
    set_req(1, 5, 5);
    req_valid[1] = 1'b1;
    wait_grant(1, "t5_grant");
    check("t5_data_rails", 32'(mult_a_rail1), 32'b101);
    #2;
    rst_n = 1'b0;
    req_valid[1] = 1'b0;
    #1;
    check_reset_vals("t5_async");
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_flush_busy", 32'(busy), 32'd1);
    wait_idle("t5_idle");
    step();
    set_req(1, 3, 3);
    push(1, 3, 3);
    req_valid[1] = 1'b1;
    wait_grant(1, "t5_grant2");
    step();
    req_valid[1] = 1'b0;
    wait_drain("t5_drain");
    wait_idle("t5_idle2");

    // illegal 11 on product pair 3
    step();
    f_p1 = 6'b001000;
    f_p0 = 6'b001000;
    repeat (SYNC_STAGES + STABLE_CYC + 3) @(negedge clk);
    check("t6_illegal_set", 32'(illegal_err), 32'd1);
    step();
    f_p1 = '0;
    f_p0 = '0;
    repeat (10) @(negedge clk);
    check("t6_illegal_sticky", 32'(illegal_err), 32'd1);
    check("t6_idle", 32'(busy), 32'd0);

`ifdef NCL_WATCHDOG_EN
    // mult_ko stuck at 1 while in DATA
    step();
    ko_stuck = 1'b1;
    set_req(0, 1, 1);
    req_valid[0] = 1'b1;
    wait_grant(0, "t7_grant");
    step();
    req_valid[0] = 1'b0;
    t = 0;
    ever_resp = 1'b0;
    while (timeout_err !== 1'b1 && t < WDOG_CYC + 150) begin
      @(negedge clk);
      if (resp_valid) ever_resp = 1'b1;
      t++;
    end
    check("t7_timeout", 32'(timeout_err), 32'd1);
    check("t7_flush_ki", 32'(mult_ki), 32'd0);
    check("t7_flush_busy", 32'(busy), 32'd1);
    check("t7_no_resp", 32'(ever_resp), 32'd0);
    step();
    ko_stuck = 1'b0;
    wait_idle("t7_recover");
    check("t7_timeout_sticky", 32'(timeout_err), 32'd1);
`else
    ever_resp = 1'b0;
    check("t7_timeout_tied", 32'(timeout_err), 32'(ever_resp));
`endif

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
